data_fetch_load: RTL and testbench

- Operand load engine directly downstream of the control unit / instruction-fetch wrapper.
- On a start pulse from the control unit it streams a 1x1, 2x2 or 4x4 matrix tile from data memory into the selected PE operand register files.
- It then raises FETCH_DONE back to the control unit.
- It owns the data-memory read port and the PE write port for loads.

---
 rtl/data_fetch_load.sv | 136 +++++++++++++
 tb/tb_data_fetch_load.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_fetch_load.sv
// Operand tile loader: streams a 1x1/2x2/4x4 tile from data memory
// into the selected PE operand register files, then signals done.
module data_fetch_load #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_LAT   = 1,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ADDR_START,
    input  logic              ADDR_RST,
    input  logic [1:0]        DIMEN,
    input  logic [3:0]        ADDRESS,
    input  logic [1:0]        PE_SEL,
    input  logic              PE_SEL_2x2,
    input  logic              PE_SEL_4,
    output logic [AW-1:0]     MEM_ADDR,
    output logic              MEM_REN,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [3:0]        PE_WR_EN,
    output logic [3:0]        PE_WR_IDX,
    output logic [DATA_W-1:0] PE_WR_DATA,
    output logic              FETCH_DONE,
    output logic              BUSY
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]  dimen_q;
    logic [3:0]  base_q;
    logic [3:0]  mask_q;
    logic [3:0]  cnt;
    logic [3:0]  last_cnt;
    logic [3:0]  start_mask;
    logic [31:0] addr_full;

    logic [MEM_LAT-1:0] pv;
    logic [3:0]         pidx [MEM_LAT];
    logic               out_v;
    logic [3:0]         out_idx;
    logic               pipe_pending;

    always_comb begin
        start_mask = 4'b0001 << PE_SEL;
        if (PE_SEL_4)
            start_mask = 4'b1111;
        else if (PE_SEL_2x2)
            start_mask = 4'b0011 << {PE_SEL[1], 1'b0};
    end

    always_comb begin
        unique case (dimen_q)
            2'd0:    last_cnt = 4'd0;
            2'd1:    last_cnt = 4'd3;
            default: last_cnt = 4'd15;
        endcase
    end

    // Wrap modulo depth so any tile base stays inside memory.
    assign addr_full = (32'({base_q, 4'b0000}) + 32'(cnt)) % 32'(MEM_DEPTH);

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else if (ADDR_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dimen_q <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            cnt     <= '0;
        end else if (ADDR_RST) begin
            cnt <= '0;
        end else if (state == IDLE && ADDR_START) begin
            dimen_q <= DIMEN;
            base_q  <= ADDRESS;
            mask_q  <= start_mask;
            cnt     <= '0;
        end else if (state == READ) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (ADDR_START) state_nxt = READ;
            READ:  if (cnt == last_cnt) state_nxt = DRAIN;
            DRAIN: if (!pipe_pending) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || ADDR_RST) begin
            pv <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                pidx[i] <= '0;
        end else begin
            pv[0]   <= (state == READ);
            pidx[0] <= cnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    assign out_v   = pv[MEM_LAT-1];
    assign out_idx = pidx[MEM_LAT-1];

    // The exiting entry does not count: its write completes this cycle.
    assign pipe_pending = |(pv & ~(MEM_LAT'(1) << (MEM_LAT - 1)));

    always_comb begin
        MEM_REN    = (state == READ);
        MEM_ADDR   = '0;
        if (state == READ)
            MEM_ADDR = addr_full[AW-1:0];
        PE_WR_EN   = out_v ? mask_q : 4'b0000;
        PE_WR_IDX  = out_v ? out_idx : 4'b0000;
        PE_WR_DATA = out_v ? MEM_RDATA : '0;
        FETCH_DONE = (state == DONE);
        BUSY       = (state == READ) || (state == DRAIN);
    end

endmodule

// File: tb/tb_data_fetch_load.sv
// Directed + randomized bench for data_fetch_load with a
// cycle-indexed reference schedule and a latency-accurate memory.
module tb_data_fetch_load;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 0;
    logic          RST = 1;
    logic          ADDR_START = 0;
    logic          ADDR_RST = 0;
    logic [1:0]    DIMEN = 0;
    logic [3:0]    ADDRESS = 0;
    logic [1:0]    PE_SEL = 0;
    logic          PE_SEL_2x2 = 0;
    logic          PE_SEL_4 = 0;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_REN;
    logic [DW-1:0] MEM_RDATA;
    logic [3:0]    PE_WR_EN;
    logic [3:0]    PE_WR_IDX;
    logic [DW-1:0] PE_WR_DATA;
    logic          FETCH_DONE;
    logic          BUSY;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd [LAT];

    int errors = 0;
    int checks = 0;

    data_fetch_load #(
        .DATA_W(DW),
        .MEM_DEPTH(DEPTH),
        .MEM_LAT(LAT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ADDR_START(ADDR_START),
        .ADDR_RST(ADDR_RST),
        .DIMEN(DIMEN),
        .ADDRESS(ADDRESS),
        .PE_SEL(PE_SEL),
        .PE_SEL_2x2(PE_SEL_2x2),
        .PE_SEL_4(PE_SEL_4),
        .MEM_ADDR(MEM_ADDR),
        .MEM_REN(MEM_REN),
        .MEM_RDATA(MEM_RDATA),
        .PE_WR_EN(PE_WR_EN),
        .PE_WR_IDX(PE_WR_IDX),
        .PE_WR_DATA(PE_WR_DATA),
        .FETCH_DONE(FETCH_DONE),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Memory with LAT cycles of read latency; garbage when not read.
    always @(posedge CLK) begin
        rd[0] <= MEM_REN ? mem[MEM_ADDR] : DW'($urandom);
        for (int i = 1; i < LAT; i++)
            rd[i] <= rd[i-1];
    end
    assign MEM_RDATA = rd[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input int ps, input bit p2,
                                           input bit p4);
        if (p4) return 4'b1111;
        if (p2) return (ps >= 2) ? 4'b1100 : 4'b0011;
        return 4'(1 << ps);
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 16;
    endfunction

    // Expected outputs t cycles after the start edge; dead = aborted.
    task automatic check_cycle(input int t, input int n, input int base,
                               input logic [3:0] m, input bit dead);
        bit ren, wr, done, busy;
        int idx;
        ren  = !dead && t >= 1 && t <= n;
        wr   = !dead && t >= 1 + LAT && t <= n + LAT;
        done = !dead && t >= n + LAT + 1;
        busy = !dead && t >= 1 && t <= n + LAT;
        chk("ren", 32'(MEM_REN), 32'(ren));
        if (ren)
            chk("addr", 32'(MEM_ADDR), 32'((base + t - 1) % DEPTH));
        chk("wr_en", 32'(PE_WR_EN), wr ? 32'(m) : 32'd0);
        if (wr) begin
            idx = t - 1 - LAT;
            chk("wr_idx", 32'(PE_WR_IDX), 32'(idx));
            chk("wr_data", PE_WR_DATA, mem[(base + idx) % DEPTH]);
        end
        chk("done", 32'(FETCH_DONE), 32'(done));
        chk("busy", 32'(BUSY), 32'(busy));
    endtask

    task automatic scramble();
        DIMEN      = 2'($urandom);
        ADDRESS    = 4'($urandom);
        PE_SEL     = 2'($urandom);
        PE_SEL_2x2 = 1'($urandom);
        PE_SEL_4   = 1'($urandom);
    endtask

    task automatic start(input int d, input int a, input int ps,
                         input bit p2, input bit p4);
        @(negedge CLK);
        DIMEN      = 2'(d);
        ADDRESS    = 4'(a);
        PE_SEL     = 2'(ps);
        PE_SEL_2x2 = p2;
        PE_SEL_4   = p4;
        ADDR_START = 1;
    endtask

    task automatic run_load(input int d, input int a, input int ps,
                            input bit p2, input bit p4, input bit poke);
        int n = n_of(d);
        logic [3:0] m = mask_of(ps, p2, p4);
        start(d, a, ps, p2, p4);
        for (int t = 1; t <= n + LAT + 3; t++) begin
            @(negedge CLK);
            ADDR_START = poke && (t == 2);
            scramble();
            check_cycle(t, n, a * 16, m, 0);
        end
        ADDR_RST = 1;
        @(negedge CLK);
        ADDR_RST = 0;
        chk("done_clr", 32'(FETCH_DONE), 32'd0);
        chk("busy_clr", 32'(BUSY), 32'd0);
    endtask

    task automatic run_abort(input bit hard);
        logic [3:0] m = mask_of(0, 0, 1);
        start(2, 5, 0, 0, 1);
        for (int t = 1; t <= 30; t++) begin
            @(negedge CLK);
            ADDR_START = 0;
            ADDR_RST   = !hard && (t == 5);
            RST        = hard && (t == 5);
            check_cycle(t, 16, 80, m, t > 5);
            if (hard && t > 5) begin
                chk("rst_addr", 32'(MEM_ADDR), 32'd0);
                chk("rst_idx", 32'(PE_WR_IDX), 32'd0);
                chk("rst_data", PE_WR_DATA, 32'd0);
            end
        end
        ADDR_RST = 0;
        RST      = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = $urandom;
        repeat (3) @(negedge CLK);
        chk("rst_ren", 32'(MEM_REN), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_wen", 32'(PE_WR_EN), 32'd0);
        chk("rst_idx", 32'(PE_WR_IDX), 32'd0);
        chk("rst_data", PE_WR_DATA, 32'd0);
        chk("rst_done", 32'(FETCH_DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST = 0;

        run_load(0, 2, 1, 0, 0, 0);
        run_load(1, 3, 2, 1, 0, 0);
        run_load(2, 0, 0, 0, 1, 0);
        run_load(2, 3, 3, 0, 0, 0);
        run_load(2, 8, 1, 1, 0, 0);
        run_load(2, 9, 0, 0, 0, 0);
        run_load(2, 15, 2, 0, 1, 1);

        run_abort(0);
        run_load(1, 6, 3, 0, 0, 0);

        // Start together with abort in IDLE must be ignored.
        @(negedge CLK);
        ADDR_START = 1;
        ADDR_RST   = 1;
        @(negedge CLK);
        ADDR_START = 0;
        ADDR_RST   = 0;
        for (int t = 0; t < 4; t++) begin
            chk("idle_ren", 32'(MEM_REN), 32'd0);
            chk("idle_busy", 32'(BUSY), 32'd0);
            @(negedge CLK);
        end

        run_abort(1);
        run_load(0, 7, 2, 0, 0, 0);

        for (int k = 0; k < 12; k++)
            run_load($urandom_range(0, 3), $urandom_range(0, 15),
                     $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                     1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
